// File: rtl/udp_recv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// udp_recv: strips the 8-byte UDP header, filters on destination port and
// forwards payload beats with source/port/length metadata.
// Revision: 1.0
// ---------------------------------------------------------------------------
module udp_recv #(
   parameter logic [15:0] LOCAL_PORT = 16'h0400,
   parameter bit          FILTER_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        data_valid_in,
   input  logic [3:0]  data_keep_in,
   input  logic        data_last_in,
   output logic        data_ready_out,
   input  logic [31:0] ip_addr_in,
   output logic [31:0] data_out,
   output logic        data_valid_out,
   output logic [3:0]  data_keep_out,
   output logic        data_last_out,
   input  logic        data_ready_in,
   output logic [31:0] ip_addr_out,
   output logic [15:0] src_port_out,
   output logic [15:0] dest_port_out,
   output logic [15:0] length_out,
   output logic [15:0] pkt_count,
   output logic [15:0] drop_count
);

   localparam logic [1:0] S_HDR0    = 2'd0;
   localparam logic [1:0] S_HDR1    = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [1:0] S_DROP    = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] src_port_q, dst_port_q, len_q;
   logic [31:0] ip_q;
   logic        meta_pend_q;
   logic [31:0] dout_q, ip_out_q;
   logic [3:0]  keep_q;
   logic        last_q, vout_q;
   logic [15:0] src_out_q, dst_out_q, len_out_q, pkt_q, drop_q;

   logic        ready_int, in_xfer, out_free, hdr_drop, meta_load, pkt_inc, drop_inc;
   logic [15:0] pay_len;

   assign out_free  = ~vout_q | data_ready_in;
   assign ready_int = (state_q == S_PAYLOAD) ? out_free : 1'b1;
   assign in_xfer   = data_valid_in & ready_int;
   assign hdr_drop  = (data_in[31:16] < 16'd8) | (FILTER_EN & (dst_port_q != LOCAL_PORT));
   assign pay_len   = data_in[31:16] - 16'd8;
   assign meta_load = in_xfer & (state_q == S_HDR1) & ~data_last_in & ~hdr_drop;
   assign pkt_inc   = in_xfer & data_last_in &
                      (((state_q == S_HDR1) & ~hdr_drop) | (state_q == S_PAYLOAD));
   assign drop_inc  = in_xfer & (((state_q == S_HDR0) & data_last_in) |
                                 ((state_q == S_HDR1) & hdr_drop));

   always_comb begin
      state_d = state_q;
      if (in_xfer) begin
         case (state_q)
            S_HDR0:    state_d = data_last_in ? S_HDR0 : S_HDR1;
            S_HDR1: begin
               if (data_last_in)  state_d = S_HDR0;
               else if (hdr_drop) state_d = S_DROP;
               else               state_d = S_PAYLOAD;
            end
            S_PAYLOAD,
            S_DROP:    if (data_last_in) state_d = S_HDR0;
            default:   state_d = S_HDR0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_HDR0;
         src_port_q  <= '0;
         dst_port_q  <= '0;
         len_q       <= '0;
         ip_q        <= '0;
         meta_pend_q <= 1'b0;
         dout_q      <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
         vout_q      <= 1'b0;
         ip_out_q    <= '0;
         src_out_q   <= '0;
         dst_out_q   <= '0;
         len_out_q   <= '0;
         pkt_q       <= '0;
         drop_q      <= '0;
      end else begin
         state_q <= state_d;
         if (in_xfer && state_q == S_HDR0) begin
            src_port_q <= data_in[31:16];
            dst_port_q <= data_in[15:0];
            ip_q       <= ip_addr_in;
         end
         // Metadata may not change under a held output beat of the previous
         // datagram, so it is parked until the output register frees up.
         if (meta_load && out_free) begin
            ip_out_q    <= ip_q;
            src_out_q   <= src_port_q;
            dst_out_q   <= dst_port_q;
            len_out_q   <= pay_len;
            meta_pend_q <= 1'b0;
         end else if (meta_load) begin
            len_q       <= pay_len;
            meta_pend_q <= 1'b1;
         end else if (meta_pend_q && out_free) begin
            ip_out_q    <= ip_q;
            src_out_q   <= src_port_q;
            dst_out_q   <= dst_port_q;
            len_out_q   <= len_q;
            meta_pend_q <= 1'b0;
         end
         if (in_xfer && state_q == S_PAYLOAD) begin
            dout_q <= data_in;
            keep_q <= data_keep_in;
            last_q <= data_last_in;
            vout_q <= 1'b1;
         end else if (data_ready_in) begin
            vout_q <= 1'b0;
         end
         if (pkt_inc)  pkt_q  <= pkt_q + 16'd1;
         if (drop_inc) drop_q <= drop_q + 16'd1;
      end
   end

   assign data_ready_out = ~reset & ready_int;
   assign data_out       = dout_q;
   assign data_valid_out = vout_q;
   assign data_keep_out  = keep_q;
   assign data_last_out  = last_q;
   assign ip_addr_out    = ip_out_q;
   assign src_port_out   = src_out_q;
   assign dest_port_out  = dst_out_q;
   assign length_out     = len_out_q;
   assign pkt_count      = pkt_q;
   assign drop_count     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_recv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_udp_recv: self-checking bench for udp_recv (filtering and non-filtering
// instances share one input stream).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_udp_recv;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_in, ip_in;
   logic        vin, data_last_in, data_ready_in;
   logic [3:0]  data_keep_in;

   logic        d_rdy_out, d_vout, d_last, n_rdy_out, n_vout, n_last;
   logic [31:0] d_dout, d_ip, n_dout, n_ip;
   logic [3:0]  d_keep, n_keep;
   logic [15:0] d_src, d_dst, d_len, d_pkt, d_drop, n_src, n_dst, n_len, n_pkt, n_drop;

   // Each instance only sees valid when the other is also ready, so both
   // consume every beat on the same edge.
   wire vin_d = vin & n_rdy_out;
   wire vin_n = vin & d_rdy_out;

   udp_recv #(.LOCAL_PORT(16'h0400), .FILTER_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid_in(vin_d),
      .data_keep_in(data_keep_in), .data_last_in(data_last_in), .data_ready_out(d_rdy_out),
      .ip_addr_in(ip_in), .data_out(d_dout), .data_valid_out(d_vout), .data_keep_out(d_keep),
      .data_last_out(d_last), .data_ready_in(data_ready_in), .ip_addr_out(d_ip),
      .src_port_out(d_src), .dest_port_out(d_dst), .length_out(d_len),
      .pkt_count(d_pkt), .drop_count(d_drop));

   udp_recv #(.LOCAL_PORT(16'h0400), .FILTER_EN(1'b0)) dut_nf (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid_in(vin_n),
      .data_keep_in(data_keep_in), .data_last_in(data_last_in), .data_ready_out(n_rdy_out),
      .ip_addr_in(ip_in), .data_out(n_dout), .data_valid_out(n_vout), .data_keep_out(n_keep),
      .data_last_out(n_last), .data_ready_in(data_ready_in), .ip_addr_out(n_ip),
      .src_port_out(n_src), .dest_port_out(n_dst), .length_out(n_len),
      .pkt_count(n_pkt), .drop_count(n_drop));

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [31:0] ip;
      logic [15:0] sp, dp, ln;
   } exp_t;

   typedef struct {
      logic [15:0] src, dst, len;
      int          nbeats;
      bit          acc, acc_nf;
   } vec_t;

   exp_t        exp_q[$], exp_nf_q[$];
   logic [31:0] cur_b[$];
   logic [3:0]  cur_k[$];
   logic [31:0] cur_ip;
   int m_pkt = 0, m_drop = 0, m_pkt_nf = 0, m_drop_nf = 0;
   int n_chk = 0, n_fail = 0, n_out_d = 0;
   int rdy_mode = 0, bp_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a datagram is a list of beats; beat 0 holds ports, beat 1 the
   // UDP length, beats 2.. are payload delivered verbatim.
   task automatic model_dgram();
      int          n = cur_b.size();
      logic [31:0] w0, w1;
      bit          acc, acc_nf;
      exp_t        e;
      if (n < 2) begin
         m_drop++; m_drop_nf++;
         return;
      end
      w0 = cur_b[0];
      w1 = cur_b[1];
      acc_nf = (w1[31:16] >= 16'd8);
      acc    = acc_nf && (w0[15:0] == 16'h0400);
      for (int i = 2; i < n; i++) begin
         e = '{cur_b[i], cur_k[i], (i == n - 1), cur_ip, w0[31:16], w0[15:0], w1[31:16] - 16'd8};
         if (acc)    exp_q.push_back(e);
         if (acc_nf) exp_nf_q.push_back(e);
      end
      if (acc)    m_pkt++;    else m_drop++;
      if (acc_nf) m_pkt_nf++; else m_drop_nf++;
   endtask

   initial forever begin
      @(posedge clk); #1;
      bp_cyc++;
      case (rdy_mode)
         0: data_ready_in = 1'b1;
         1: data_ready_in = ($urandom_range(99) < 60);
         2: data_ready_in = (bp_cyc < 10) ? (bp_cyc % 2 == 0) : (bp_cyc >= 15);
         default: ;
      endcase
   end

   // Output monitor: metadata must match the head beat whenever valid is up.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (d_vout && exp_q.size() == 0) chk("dut_spurious_valid", d_vout, 1'b0);
         else if (d_vout) begin
            chk("dut_meta", {d_ip, d_src, d_dst}, {exp_q[0].ip, exp_q[0].sp, exp_q[0].dp});
            chk("dut_len", d_len, exp_q[0].ln);
            if (data_ready_in) begin
               chk("dut_beat", {d_dout, d_keep, d_last}, {exp_q[0].d, exp_q[0].k, exp_q[0].l});
               void'(exp_q.pop_front());
               n_out_d++;
            end
         end
         if (n_vout && exp_nf_q.size() == 0) chk("nf_spurious_valid", n_vout, 1'b0);
         else if (n_vout) begin
            chk("nf_meta", {n_ip, n_src, n_dst}, {exp_nf_q[0].ip, exp_nf_q[0].sp, exp_nf_q[0].dp});
            chk("nf_len", n_len, exp_nf_q[0].ln);
            if (data_ready_in) begin
               chk("nf_beat", {n_dout, n_keep, n_last}, {exp_nf_q[0].d, exp_nf_q[0].k, exp_nf_q[0].l});
               void'(exp_nf_q.pop_front());
            end
         end
      end
   end

   // mode 1: output held in payload must stall input; mode 2: dropping DUT must stay ready
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int mode);
      int t = 0;
      bit done = 0;
      data_in = d; data_keep_in = k; data_last_in = l; vin = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (mode == 1 && d_vout && !data_ready_in) chk("bp_ready_low", d_rdy_out, 1'b0);
         if (mode == 2 && t == 0) chk("drop_ready_high", d_rdy_out, 1'b1);
         done = d_rdy_out & n_rdy_out;
         @(posedge clk); #1;
         t++;
         if (!done && t > 300) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, t);
            done = 1;
         end
      end
      vin = 1'b0;
   endtask

   task automatic send_dgram(input int nstop, input int gap_pct, input int mode);
      ip_in = cur_ip;
      for (int i = 0; i < nstop; i++) begin
         for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
            @(posedge clk); #1;
         end
         send_beat(cur_b[i], cur_k[i], (i == cur_b.size() - 1),
                   (mode == 1 && i >= 2) ? 1 : ((mode == 2) ? 2 : 0));
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || exp_nf_q.size() != 0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_empty", exp_q.size() + exp_nf_q.size(), 0);
      @(posedge clk); #1;
      chk("pkt_count", d_pkt, m_pkt[15:0]);
      chk("drop_count", d_drop, m_drop[15:0]);
      chk("nf_pkt_count", n_pkt, m_pkt_nf[15:0]);
      chk("nf_drop_count", n_drop, m_drop_nf[15:0]);
   endtask

   task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ln,
                        input int nb);
      cur_b.delete(); cur_k.delete();
      cur_b.push_back({sp, dp});
      cur_k.push_back(4'hF);
      for (int i = 1; i < nb; i++) begin
         cur_b.push_back((i == 1) ? {ln, 16'($urandom)} : $urandom);
         cur_k.push_back((i == nb - 1) ? 4'($urandom_range(1, 15)) : 4'hF);
      end
      cur_ip = $urandom;
   endtask

   vec_t tbl[7];
   logic [15:0] p0, d0, p1, d1;

   initial begin
      tbl[0] = '{16'h1234, 16'h0400, 16'd20, 5, 1'b1, 1'b1};
      tbl[1] = '{16'h1234, 16'h0401, 16'd20, 5, 1'b0, 1'b1};
      tbl[2] = '{16'h1234, 16'h0400, 16'd4,  5, 1'b0, 1'b0};
      tbl[3] = '{16'h1234, 16'h0400, 16'd0,  1, 1'b0, 1'b0};
      tbl[4] = '{16'h1234, 16'h0400, 16'd8,  2, 1'b1, 1'b1};
      tbl[5] = '{16'h0400, 16'h0400, 16'd7,  2, 1'b0, 1'b0};
      tbl[6] = '{16'hABCD, 16'h0400, 16'd8,  3, 1'b1, 1'b1};

      reset = 1'b1; vin = 1'b0; data_in = '0; data_keep_in = '0; data_last_in = 1'b0;
      ip_in = '0; data_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {d_dout, d_vout, d_keep, d_last, d_rdy_out}, 39'd0);
      chk("rst_meta", {d_ip, d_src, d_dst}, 64'd0);
      chk("rst_cnt", {d_len, d_pkt, d_drop}, 48'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // basic accept with cycle-exact latency
      cur_b = '{32'h1234_0400, 32'h0014_ABCD, 32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5};
      cur_k = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      cur_ip = 32'hC0A8_0001;
      ip_in = cur_ip;
      model_dgram();
      for (int i = 0; i < 5; i++) begin
         data_in = cur_b[i]; data_keep_in = cur_k[i]; data_last_in = (i == 4); vin = 1'b1;
         chk("basic_ready", {d_rdy_out, n_rdy_out}, 2'b11);
         @(posedge clk); #1;
         if (i == 1) chk("basic_meta", {d_src, d_dst, d_len, d_vout}, {16'h1234, 16'h0400, 16'd12, 1'b0});
         if (i == 2) chk("basic_latency", {d_vout, d_dout}, {1'b1, 32'hDEADBEEF});
      end
      vin = 1'b0;
      chk("basic_pkt", d_pkt, 16'd1);
      drain();

      // header/filter table
      for (int v = 0; v < 7; v++) begin
         p0 = d_pkt; d0 = d_drop; p1 = n_pkt; d1 = n_drop;
         build(tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].nbeats);
         model_dgram();
         send_dgram(cur_b.size(), 0, tbl[v].acc ? 0 : 2);
         drain();
         chk("tbl_acc", {d_pkt - p0, d_drop - d0}, {16'(tbl[v].acc), 16'(!tbl[v].acc)});
         chk("tbl_acc_nf", {n_pkt - p1, n_drop - d1}, {16'(tbl[v].acc_nf), 16'(!tbl[v].acc_nf)});
      end

      // back-pressure: 1010... then held low over a 6-beat payload
      build(16'h7777, 16'h0400, 16'd32, 8);
      model_dgram();
      bp_cyc = 0; rdy_mode = 2;
      send_dgram(8, 0, 1);
      drain();
      rdy_mode = 0;

      // back-to-back datagrams under random back-pressure
      rdy_mode = 1;
      for (int r = 0; r < 4; r++) begin
         build(16'h1234, 16'h0400, 16'd12, 5);
         model_dgram();
         send_dgram(5, 0, 0);
         build(16'h5555, 16'h0400, 16'd8 + 16'($urandom_range(0, 3) * 4), 2 + $urandom_range(0, 3));
         model_dgram();
         send_dgram(cur_b.size(), 0, 0);
      end
      drain();
      rdy_mode = 0;

      // reset after two payload beats have left
      build(16'h2222, 16'h0400, 16'd24, 6);
      model_dgram();
      n_out_d = 0;
      send_dgram(5, 0, 0);
      chk("rst_mid_outbeats", n_out_d, 2);
      reset = 1'b1;
      #1;
      chk("rst_mid_data", {d_dout, d_vout, d_keep, d_last, d_rdy_out}, 39'd0);
      chk("rst_mid_meta", {d_ip, d_src, d_dst}, 64'd0);
      chk("rst_mid_cnt", {d_len, d_pkt, d_drop}, 48'd0);
      exp_q.delete(); exp_nf_q.delete();
      m_pkt = 0; m_drop = 0; m_pkt_nf = 0; m_drop_nf = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      build(16'h3333, 16'h0400, 16'd16, 4);
      model_dgram();
      send_dgram(4, 0, 0);
      drain();

      // randomized traffic
      for (int r = 0; r < 40; r++) begin
         int nb = $urandom_range(1, 7);
         rdy_mode = $urandom_range(0, 1);
         build(16'($urandom), ($urandom_range(0, 1) != 0) ? 16'h0400 : 16'($urandom),
               ($urandom_range(0, 3) != 0) ? 16'((nb > 2 ? nb - 2 : 0) * 4 + 8) : 16'($urandom_range(0, 40)),
               nb);
         model_dgram();
         send_dgram(nb, 30, 0);
         if (r % 5 == 4) drain();
      end
      rdy_mode = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
